// File: rtl/arith_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arith_pkg
// Purpose  : Shared op/state encodings, counter width and latency helper
//            for the arith_issue block.
// Revision : 1.0
// ============================================================================
package arith_pkg;

    localparam int          c_CNT_W       = 5;
    localparam logic [31:0] c_DIVZ_RESULT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_MUL  = 2'b01,
        OP_DIV  = 2'b10,
        OP_PASS = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Counter preload for an op: its latency minus one (pass-A is single-cycle).
    function automatic logic [c_CNT_W-1:0] lat_load(input op_e op, input int add_lat,
                                                    input int mul_lat, input int div_lat);
        int lat;
        case (op)
            OP_ADD:  lat = add_lat;
            OP_MUL:  lat = mul_lat;
            OP_DIV:  lat = div_lat;
            default: lat = 1;
        endcase
        return c_CNT_W'(lat - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/arith_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : arith_issue_ctrl
// Purpose  : IDLE/BUSY/DONE sequencer and latency counter for arith_issue.
// Revision : 1.0
// ============================================================================
module arith_issue_ctrl
    import arith_pkg::*;
#(
    parameter int ADD_LAT = 1,
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 8
) (
    input  logic       phi,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [1:0] in_op,
    input  logic       divz_req,
    input  logic       out_ready,
    output logic       in_ready,
    output logic       out_valid,
    output logic       accept,
    output logic       direct,
    output logic       divz_hit,
    output logic       capture
);

    state_e               r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic [c_CNT_W-1:0]   w_load;

    assign w_load    = lat_load(op_e'(in_op), ADD_LAT, MUL_LAT, DIV_LAT);
    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign accept    = in_valid & r_in_ready;
    assign divz_hit  = accept & divz_req;
    assign direct    = accept & ~divz_req & (w_load == '0);
    // Counter holds remaining cycles; the last BUSY cycle is when it reads 1.
    assign capture   = (r_state == ST_BUSY) && (r_cnt == c_CNT_W'(1));

    always_ff @(posedge phi or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (accept) begin
                        r_in_ready <= 1'b0;
                        if (divz_req || (w_load == '0)) begin
                            r_state     <= ST_DONE;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state <= ST_BUSY;
                            r_cnt   <= w_load;
                        end
                    end
                end
                ST_BUSY: begin
                    r_cnt <= r_cnt - c_CNT_W'(1);
                    if (capture) begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_cnt       <= '0;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/arith_issue.sv
`default_nettype none
// ============================================================================
// Module   : arith_issue
// Purpose  : Single-issue add/mul/div/pass unit with per-op fixed latency.
//            Optional macro ARITH_DIVZERO_CHECK_EN flags divide-by-zero.
// Revision : 1.0
// ============================================================================
module arith_issue
    import arith_pkg::*;
#(
    parameter int ADD_LAT = 1,
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 8
) (
    input  logic        phi,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_op,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_err
);

    op_e         r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_out_data;
    logic        r_bypass;

    logic        w_accept;
    logic        w_direct;
    logic        w_divz_hit;
    logic        w_capture;
    logic        w_divz_req;
    logic [31:0] w_adder32;
    logic [31:0] w_mult32;
    logic [31:0] w_div32;
    logic [31:0] w_result;

    arith_issue_ctrl #(
        .ADD_LAT (ADD_LAT),
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) u_ctrl (
        .phi       (phi),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_op     (in_op),
        .divz_req  (w_divz_req),
        .out_ready (out_ready),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .accept    (w_accept),
        .direct    (w_direct),
        .divz_hit  (w_divz_hit),
        .capture   (w_capture)
    );

    // Arithmetic units see only the operand registers, so they settle over
    // the whole BUSY window as a multicycle path.
    assign w_adder32 = r_a + r_b;
    assign w_mult32  = r_a * r_b;
    assign w_div32   = r_a / r_b;

    always_comb begin
        w_result = r_a;
        case (r_op)
            OP_ADD:  w_result = w_adder32;
            OP_MUL:  w_result = w_mult32;
            OP_DIV:  w_result = w_div32;
            default: w_result = r_a;
        endcase
    end

    // Single-cycle ops go straight to DONE, so their result is shown live
    // from the (now frozen) operand registers instead of a captured copy.
    assign out_data = r_bypass ? w_result : r_out_data;

    always_ff @(posedge phi or negedge rst_n) begin
        if (!rst_n) begin
            r_op       <= OP_ADD;
            r_a        <= '0;
            r_b        <= '0;
            r_out_data <= '0;
            r_bypass   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op     <= op_e'(in_op);
                r_a      <= in_a;
                r_b      <= in_b;
                r_bypass <= w_direct;
            end
            if (w_divz_hit) begin
                r_out_data <= c_DIVZ_RESULT;
            end else if (w_capture) begin
                r_out_data <= w_result;
            end
        end
    end

`ifdef ARITH_DIVZERO_CHECK_EN
    logic r_err;

    assign w_divz_req = (in_op == OP_DIV) && (in_b == '0);
    assign out_err    = r_err;

    always_ff @(posedge phi or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= w_divz_hit;
        end
    end
`else
    assign w_divz_req = 1'b0;
    assign out_err    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_arith_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_arith_issue
// Purpose  : Directed and randomized checks of arith_issue against a
//            behavioural latency/result model.
// Revision : 1.0
// ============================================================================
module tb_arith_issue;

    localparam int ADD_LAT = 1;
    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = 8;

    logic        phi       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b0;
    logic [1:0]  in_op     = 2'b00;
    logic [31:0] in_a      = '0;
    logic [31:0] in_b      = '0;
    logic        in_ready;
    logic        out_valid;
    logic        out_err;
    logic [31:0] out_data;

    int n_chk = 0;
    int n_err = 0;

    always #5 phi = ~phi;

    arith_issue #(
        .ADD_LAT (ADD_LAT),
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) dut (
        .phi       (phi),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Reference: result, error flag and latency computed from the op rules.
    task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] d, output logic e, output int lat,
                         output bit known);
        logic [63:0] p;
        e = 1'b0;
        known = 1'b1;
        d = '0;
        case (op)
            2'b00: begin d = a + b; lat = ADD_LAT; end
            2'b01: begin p = {32'd0, a} * {32'd0, b}; d = p[31:0]; lat = MUL_LAT; end
            2'b10: begin
                if (b == 0) begin
`ifdef ARITH_DIVZERO_CHECK_EN
                    d = 32'hFFFF_FFFF; e = 1'b1; lat = 1;
`else
                    known = 1'b0; lat = DIV_LAT;
`endif
                end else begin
                    d = a / b; lat = DIV_LAT;
                end
            end
            default: begin d = a; lat = 1; end
        endcase
    endtask

    task automatic scramble();
        in_valid  = 1'($urandom);
        in_op     = 2'($urandom);
        in_a      = $urandom;
        in_b      = $urandom;
        out_ready = 1'($urandom);
    endtask

    task automatic do_txn(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int hold);
        logic [31:0] exp_d;
        logic        exp_e;
        int          lat;
        bit          known;
        int          n;
        model(op, a, b, exp_d, exp_e, lat, known);
        n = 0;
        while (!in_ready && n < 50) begin @(negedge phi); n++; end
        check("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; out_ready = 1'b0;
        @(posedge phi);
        @(negedge phi);
        n = 1;
        while (!out_valid && n < 40) begin
            check("in_ready_busy", 32'(in_ready), 32'd0);
            scramble();
            @(negedge phi);
            n++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        check("latency", 32'(n), 32'(lat));
        check("out_valid", 32'(out_valid), 32'd1);
        if (known) check("data", out_data, exp_d);
        check("err", 32'(out_err), 32'(exp_e));
        check("in_ready_done", 32'(in_ready), 32'd0);
        repeat (hold) begin
            in_a = $urandom; in_b = $urandom;
            @(negedge phi);
            check("hold_valid", 32'(out_valid), 32'd1);
            if (known) check("hold_data", out_data, exp_d);
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge phi);
        out_ready = 1'b0;
        check("drained", 32'(out_valid), 32'd0);
        check("in_ready_after", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit quiet;
        logic [31:0] ra;
        logic [31:0] rb;

        repeat (2) @(negedge phi);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        rst_n = 1'b1;

        do_txn(2'b00, 32'hFFFF_FFFF, 32'd2, 0);
        do_txn(2'b01, 32'h0001_0000, 32'h0001_0001, 1);
        do_txn(2'b10, 32'd100, 32'd7, 5);
        do_txn(2'b10, 32'd5, 32'd0, 1);
        do_txn(2'b11, 32'h1234_5678, 32'hDEAD_BEEF, 2);

        // Reset during a divide abandons it.
        @(negedge phi);
        in_valid = 1'b1; in_op = 2'b10; in_a = 32'd100; in_b = 32'd7;
        @(posedge phi);
        @(negedge phi);
        in_valid = 1'b0;
        repeat (3) @(posedge phi);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_data", out_data, 32'd0);
        check("midrst_out_err", 32'(out_err), 32'd0);
        @(negedge phi);
        rst_n = 1'b1;
        quiet = 1'b1;
        repeat (10) begin
            @(negedge phi);
            if (out_valid) quiet = 1'b0;
        end
        check("midrst_no_result", 32'(quiet), 32'd1);
        do_txn(2'b00, 32'd3, 32'd4, 0);

        // Back-to-back with in_valid held high across the drain edge.
        @(negedge phi);
        out_ready = 1'b1; in_valid = 1'b1; in_op = 2'b00; in_a = 32'd1; in_b = 32'd1;
        @(posedge phi);
        @(negedge phi);
        in_op = 2'b11; in_a = 32'h55; in_b = 32'd0;
        check("b2b_first_valid", 32'(out_valid), 32'd1);
        check("b2b_first_data", out_data, 32'd2);
        check("b2b_first_in_ready", 32'(in_ready), 32'd0);
        @(negedge phi);
        check("b2b_gap_valid", 32'(out_valid), 32'd0);
        check("b2b_gap_in_ready", 32'(in_ready), 32'd1);
        @(negedge phi);
        in_valid = 1'b0;
        check("b2b_second_valid", 32'(out_valid), 32'd1);
        check("b2b_second_data", out_data, 32'h55);
        @(negedge phi);
        out_ready = 1'b0;
        check("b2b_second_drained", 32'(out_valid), 32'd0);

        for (int i = 0; i < 60; i++) begin
            ra = $urandom;
            rb = (i % 2 == 0) ? $urandom : 32'($urandom_range(0, 1000));
            do_txn(2'($urandom), ra, rb, int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
